// File: rtl/alu_sub_arbiter.sv
// Round-robin shared 32-bit add/subtract unit with valid/ready response port.
// Optional {carry_borrow, zero} flags output enabled by `define ALU_SUB_FLAGS_EN.
module alu_sub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      busy
`ifdef ALU_SUB_FLAGS_EN
    ,
    output logic [1:0]                rsp_flags
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_op;
    logic [DATA_W-1:0]   r_result;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;

    logic                w_any;
    logic [ID_W-1:0]     w_win;
    logic                w_take;
    logic [NUM_REQ-1:0]  w_grant;
    logic [DATA_W-1:0]   w_res;

    // Lowest rotation offset from last_grant+1 wins, so scan offsets downward.
    always_comb begin
        w_any = |req_valid;
        w_win = r_last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            int k;
            k = (int'(r_last) + i) % NUM_REQ;
            if (req_valid[k[IW-1:0]]) begin
                w_win = ID_W'(k);
            end
        end
    end

    // Gate with reset so no grant is visible while the block is held in reset.
    assign w_take  = (r_state == S_IDLE) && n_rst && w_any;
    assign w_grant = w_take ? (NUM_REQ'(1) << w_win) : '0;

`ifdef ALU_SUB_FLAGS_EN
    logic [DATA_W:0] w_full;
    logic            w_cb;
    logic [1:0]      r_flags;

    assign w_full = r_op ? ({1'b0, r_a} + {1'b0, r_b})
                         : ({1'b0, r_a} - {1'b0, r_b});
    assign w_res  = w_full[DATA_W-1:0];
    assign w_cb   = w_full[DATA_W];
`else
    assign w_res  = r_op ? (r_a + r_b) : (r_a - r_b);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_last      <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_result    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
`ifdef ALU_SUB_FLAGS_EN
            r_flags     <= 2'b00;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_a     <= req_a[int'(w_win)*DATA_W +: DATA_W];
                        r_b     <= req_b[int'(w_win)*DATA_W +: DATA_W];
                        r_op    <= req_op[w_win[IW-1:0]];
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result    <= w_res;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
`ifdef ALU_SUB_FLAGS_EN
                    r_flags     <= {w_cb, (w_res == '0)};
`endif
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_result;
    assign busy       = (r_state != S_IDLE);
`ifdef ALU_SUB_FLAGS_EN
    assign rsp_flags  = r_flags;
`endif

endmodule

// File: tb/tb_alu_sub_arbiter.sv
// Directed bench for alu_sub_arbiter: reset, arithmetic wrap, round robin,
// backpressure and reset mid-transaction.
module tb_alu_sub_arbiter;

    logic         clk;
    logic         n_rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         busy;
`ifdef ALU_SUB_FLAGS_EN
    logic [1:0]   rsp_flags;
`endif

    int n_pass;
    int n_total;

    alu_sub_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef ALU_SUB_FLAGS_EN
        ,
        .rsp_flags  (rsp_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_flags(input string tag, input logic [1:0] exp);
`ifdef ALU_SUB_FLAGS_EN
        chk(tag, {30'd0, rsp_flags}, {30'd0, exp});
`else
        if (exp === 2'bxx) $display("unused %s", tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [31:0] a,
                            input logic [31:0] b, input logic op);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_op[i]         = op;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        n_rst     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;

        // reset held with all lanes requesting
        tick(); tick(); tick();
        chk("rst_ready", {28'd0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_id", {30'd0, rsp_id}, 32'h0);

        set_lane(0, 32'd5, 32'd5, 1'b1);
        n_rst = 1'b1;
        #1;
        chk("first_grant", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'h0;
        chk("exec_busy", {31'd0, busy}, 32'h1);
        chk("exec_ready", {28'd0, req_ready}, 32'h0);
        chk("exec_no_rsp", {31'd0, rsp_valid}, 32'h0);
        tick();
        chk("first_rsp_valid", {31'd0, rsp_valid}, 32'h1);
        chk("first_rsp_id", {30'd0, rsp_id}, 32'h0);
        chk("first_rsp_result", rsp_result, 32'd10);
        rsp_ready = 1'b1;
        tick();
        chk("first_idle_valid", {31'd0, rsp_valid}, 32'h0);
        chk("first_idle_busy", {31'd0, busy}, 32'h0);

        // single subtract on lane 2
        set_lane(2, 32'd10, 32'd3, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("sub_grant", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = 4'h0;
        tick();
        chk("sub_valid", {31'd0, rsp_valid}, 32'h1);
        chk("sub_id", {30'd0, rsp_id}, 32'd2);
        chk("sub_result", rsp_result, 32'd7);
        chk_flags("sub_flags", 2'b00);
        tick();

        // 0 - 1 wraps with borrow
        set_lane(0, 32'd0, 32'd1, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("wrap_sub_grant", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'h0;
        tick();
        chk("wrap_sub_result", rsp_result, 32'hFFFF_FFFF);
        chk_flags("wrap_sub_flags", 2'b10);
        tick();

        // all ones + 1 wraps with carry and zero
        set_lane(0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        req_valid = 4'b0001;
        #1;
        chk("wrap_add_grant", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'h0;
        tick();
        chk("wrap_add_result", rsp_result, 32'h0);
        chk_flags("wrap_add_flags", 2'b11);
        tick();

        // round robin from a fresh pointer
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        set_lane(0, 32'd100, 32'd1, 1'b1);
        set_lane(1, 32'd200, 32'd2, 1'b0);
        set_lane(2, 32'd300, 32'd3, 1'b1);
        set_lane(3, 32'd400, 32'd4, 1'b0);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        chk("rr_grant0", {28'd0, req_ready}, 32'h1);
        tick();
        chk("rr_exec0", {28'd0, req_ready}, 32'h0);
        tick();
        chk("rr_id0", {30'd0, rsp_id}, 32'd0);
        chk("rr_res0", rsp_result, 32'd101);
        tick();
        chk("rr_grant1", {28'd0, req_ready}, 32'h2);
        tick();
        chk("rr_exec1", {28'd0, req_ready}, 32'h0);
        tick();
        chk("rr_id1", {30'd0, rsp_id}, 32'd1);
        chk("rr_res1", rsp_result, 32'd198);
        tick();
        chk("rr_grant2", {28'd0, req_ready}, 32'h4);
        tick();
        chk("rr_exec2", {28'd0, req_ready}, 32'h0);
        tick();
        chk("rr_id2", {30'd0, rsp_id}, 32'd2);
        chk("rr_res2", rsp_result, 32'd303);
        tick();
        chk("rr_grant3", {28'd0, req_ready}, 32'h8);
        tick();
        chk("rr_exec3", {28'd0, req_ready}, 32'h0);
        tick();
        chk("rr_id3", {30'd0, rsp_id}, 32'd3);
        chk("rr_res3", rsp_result, 32'd396);
        tick();
        chk("rr_grant4", {28'd0, req_ready}, 32'h1);
        tick();
        chk("rr_exec4", {28'd0, req_ready}, 32'h0);
        tick();
        chk("rr_id4", {30'd0, rsp_id}, 32'd0);
        tick();
        req_valid = 4'h0;

        // backpressure on lane 1 while other lanes keep requesting
        rsp_ready = 1'b0;
        set_lane(1, 32'd20, 32'd22, 1'b1);
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = 4'hF;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'h1);
            chk("bp_id", {30'd0, rsp_id}, 32'd1);
            chk("bp_result", rsp_result, 32'd42);
            chk("bp_ready", {28'd0, req_ready}, 32'h0);
            chk("bp_busy", {31'd0, busy}, 32'h1);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 4'h0;
        tick();
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'h0);
        chk("bp_release_busy", {31'd0, busy}, 32'h0);

        // reset during EXEC of lane 3 discards the transaction
        set_lane(3, 32'd9, 32'd4, 1'b0);
        req_valid = 4'b1000;
        #1;
        chk("mid_grant", {28'd0, req_ready}, 32'h8);
        tick();
        req_valid = 4'h0;
        chk("mid_exec_busy", {31'd0, busy}, 32'h1);
        n_rst = 1'b0;
        #2;
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'h0);
        n_rst = 1'b1;
        tick();
        chk("mid_no_rsp_a", {31'd0, rsp_valid}, 32'h0);
        tick();
        chk("mid_no_rsp_b", {31'd0, rsp_valid}, 32'h0);
        set_lane(0, 32'd50, 32'd8, 1'b0);
        req_valid = 4'b1001;
        #1;
        chk("mid_regrant", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'h0;
        tick();
        chk("mid_regrant_id", {30'd0, rsp_id}, 32'd0);
        chk("mid_regrant_res", rsp_result, 32'd42);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
